id_pipe: RTL and testbench
==========================

# id_pipe

Pipelined RV32I decode stage that sits between fetch and the ALU/memory stages of the homebrew core. It accepts one instruction per cycle over a valid/ready handshake, decodes it into the existing ALU/memory control encodings, and resolves branches and jumps. It holds decoded micro-ops in a parametrised output buffer, interlocks on register hazards, and issues a registered redirect with a one-cycle wrong-path shadow. With `RV32M_EN` defined it also decodes the M extension.

## Interface
- BUF_DEPTH, 2, decoded-entry buffer depth; legal values 1, 2, 4.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_pc, in_inst  in  32 each  instruction address and word.
- qa  in  32  rs1 read data for in_inst; regfile is write-through.
- is_lt, is_ltu, is_zero  in  1 each  rs1-vs-rs2 compare flags for in_inst.
- ex_rd  in  5  destination of the instruction in EX; 0 = none.
- ex_is_load  in  1  the instruction in EX is a load.
- flush  in  1  discard all buffered entries and the shadow.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  EX consumes the head.
- out_pc  out  32; out_rd, out_rs1, out_rs2  out  5 each.
- out_alu_src_1, out_alu_src_2  out  1 each; out_alu_imm_1, out_alu_imm_2  out  32 each.
- out_alu_op  out  8; out_mem_op  out  10; out_reg_we  out  1.
- out_mul_op  out  4  {valid, funct3}; tied to 0 without `RV32M_EN`.
- out_illegal  out  1  undecodable instruction.
- redirect  out  1  one-cycle pulse: fetch restarts at redirect_addr.
- redirect_addr  out  32  target, bit 0 cleared.

## Operation
- Decoding uses the existing RV32I encodings:
  - Opcode classes: lui, auipc, jal, jalr, branch, load, store, op-imm, op.
  - Immediates: U/J/I/B/S.
  - alu_op: one-hot slt/sltu/sll/srl/sra plus the 74x381 select.
  - mem_op: sign/byte/half/word/load/store/byte-enables.
  - alu_src and alu_imm rules: imm_1 is pc for auipc/jal/jalr, else 0; imm_2 is 4 for jal/jalr, else the immediate.
- Illegal instructions are enqueued with out_illegal=1, reg_we=0, mem_op=0 and produce no redirect. An instruction is illegal when:
  - its opcode is outside the nine classes, or
  - its funct3 is reserved for load, store or branch, or
  - op/op-imm funct7 is invalid.
- Taken condition: jal, jalr, or a branch whose funct3 selects beq, bne, blt, bge, bltu or bgeu with the matching flag.
- Target: (jalr ? qa : in_pc) + imm, with bit 0 cleared.
- Hazard stall (in_ready=0) applies to both groups of consumers:
  - Decode-time consumers (branch rs1/rs2, jalr rs1) stall when they match a nonzero ex_rd, or the rd of any buffered entry with reg_we=1.
  - Any used rs1/rs2 stalls when it matches a nonzero ex_rd while ex_is_load=1.
- Buffer is a circular FIFO with rd/wr pointers that wrap modulo BUF_DEPTH and a count of 0..BUF_DEPTH.
- in_ready = (count < BUF_DEPTH) & ~stall, except in SHADOW.
- State machine:
  - NORMAL to SHADOW on acceptance of a taken instruction.
  - SHADOW to NORMAL unconditionally after one cycle.
  - In SHADOW, in_ready=1 and the input is discarded, not enqueued.
- The taken instruction itself is enqueued so jal/jalr link writes proceed.
- Push and pop in the same cycle leave count unchanged. At count=BUF_DEPTH no push occurs.
- flush: next cycle count=0, pointers=0, state=NORMAL, redirect=0. flush overrides a same-cycle push and redirect.

## Timing
- Decode is combinational from in_inst. Each entry is registered on acceptance, so out_valid rises 1 cycle after acceptance (latency 1).
- Outputs are driven from the buffer head. They are held stable while out_valid & ~out_ready.
- redirect/redirect_addr are registered: a taken instruction accepted in cycle N gives redirect=1 in N+1 only. Fetch presents the target in N+2.
- Reset: count=0, pointers=0, state=NORMAL.
- Outputs after reset:
  - redirect=0, redirect_addr=0.
  - out_valid=0; all out_* = 0.
  - in_ready=1 once rst falls (no stall sources).
- Reset asserted mid-operation drops all buffered entries and any pending redirect on the same edge.

## Configuration
- `RV32M_EN` defined: op with funct7=0000001 decodes as M, giving out_mul_op={1, funct3}, reg_we=1 and alu_op=0.
- `RV32M_EN` undefined: that encoding is illegal and out_mul_op is constant 0.

## Test plan
- Reset, then addi x1,x0,5 at pc 0x100 -> next cycle out_valid=1, out_pc=0x100, out_alu_imm_2=5, out_reg_we=1, out_rd=1.
- BUF_DEPTH=2, out_ready=0, three valid instructions -> first two accepted, in_ready=0 on the third. One pop -> third accepted, FIFO order preserved across pointer wrap.
- beq at 0x200, imm=+0x40, is_zero=1 -> redirect=1 with redirect_addr=0x240 one cycle later. Instruction offered in that cycle is dropped. beq still delivered.
- jalr with qa=0x1003, imm=4 -> redirect_addr=0x1006, out_alu_imm_1=pc, out_alu_imm_2=4.
- ex_rd=5 with ex_is_load=1, incoming add x6,x5,x7 -> in_ready=0 until ex_rd changes. Same flags with a non-load in EX -> accepted.
- flush with 2 buffered entries plus a simultaneous taken jal -> next cycle out_valid=0, redirect=0. mul x1,x2,x3 -> out_mul_op=4'b1000 with `RV32M_EN`, out_illegal=1 without.

Source files
------------

// File: rtl/id_pipe.sv
// id_pipe: RV32I decode stage with hazard interlock, decoded-entry FIFO and registered redirect; define RV32M_EN to decode the M extension
module id_pipe #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic [31:0] qa,
  input  logic        is_lt,
  input  logic        is_ltu,
  input  logic        is_zero,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic        out_alu_src_1,
  output logic        out_alu_src_2,
  output logic [31:0] out_alu_imm_1,
  output logic [31:0] out_alu_imm_2,
  output logic [7:0]  out_alu_op,
  output logic [9:0]  out_mem_op,
  output logic        out_reg_we,
  output logic [3:0]  out_mul_op,
  output logic        out_illegal,
  output logic        redirect,
  output logic [31:0] redirect_addr
);
  localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int EW = 137;
  localparam int RD_LSB = 100;
  localparam int WE_BIT = 5;
  typedef enum logic {NORMAL, SHADOW} state_t;
  state_t state, state_n;
  logic [6:0] opc, f7;
  logic [2:0] f3, sel;
  logic [4:0] rd, rs1, rs2;
  logic c_lui, c_auipc, c_jal, c_jalr, c_br, c_ld, c_st, c_opi, c_op, is_m, ill;
  logic use1, use2, we, arith, asub, bt, taken, stall, buf_hz, push, pop;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm, target;
  logic [7:0] alu_op;
  logic [9:0] mem_op;
  logic [3:0] be, mul_op;
  logic [EW-1:0] ent;
  logic [EW-1:0] buf_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] vld;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  assign opc = in_inst[6:0];
  assign rd = in_inst[11:7];
  assign f3 = in_inst[14:12];
  assign rs1 = in_inst[19:15];
  assign rs2 = in_inst[24:20];
  assign f7 = in_inst[31:25];
  assign c_lui = opc == 7'b0110111;
  assign c_auipc = opc == 7'b0010111;
  assign c_jal = opc == 7'b1101111;
  assign c_jalr = opc == 7'b1100111;
  assign c_br = opc == 7'b1100011;
  assign c_ld = opc == 7'b0000011;
  assign c_st = opc == 7'b0100011;
  assign c_opi = opc == 7'b0010011;
  assign c_op = opc == 7'b0110011;
`ifdef RV32M_EN
  assign is_m = c_op & (f7 == 7'b0000001);
`else
  assign is_m = 1'b0;
`endif
  assign ill = ~(c_lui | c_auipc | c_jal | c_jalr | c_br | c_ld | c_st | c_opi | c_op)
             | (c_br & (f3[2:1] == 2'b01))
             | (c_ld & ((f3 == 3'b011) | (f3[2:1] == 2'b11)))
             | (c_st & (f3[2] | (f3[1:0] == 2'b11)))
             | (c_opi & (f3 == 3'b001) & (f7 != 7'b0))
             | (c_opi & (f3 == 3'b101) & (f7 != 7'b0) & (f7 != 7'b0100000))
             | (c_op & ~((f7 == 7'b0) | ((f7 == 7'b0100000) & ((f3 == 3'b000) | (f3 == 3'b101))) | is_m));
  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign imm = (c_lui | c_auipc) ? imm_u : c_jal ? imm_j : c_br ? imm_b : c_st ? imm_s
             : (c_jalr | c_ld | c_opi) ? imm_i : 32'b0;
  assign use1 = ~ill & (c_jalr | c_br | c_ld | c_st | c_opi | c_op);
  assign use2 = ~ill & (c_br | c_st | c_op);
  assign we = ~ill & (c_lui | c_auipc | c_jal | c_jalr | c_ld | c_opi | c_op);
  assign arith = (c_opi | c_op) & ~is_m;
  assign asub = c_op & f7[5] & (f3 == 3'b000);
  assign sel = arith ? ((f3 == 3'd0) ? (asub ? 3'b010 : 3'b011) : (f3[2:1] == 2'b01) ? 3'b010
             : (f3 == 3'd4) ? 3'b100 : (f3 == 3'd6) ? 3'b101 : (f3 == 3'd7) ? 3'b110 : 3'b000)
             : c_br ? 3'b010 : (c_lui | c_auipc | c_jal | c_jalr | c_ld | c_st) ? 3'b011 : 3'b000;
  assign alu_op = ill ? 8'b0 : {arith & (f3 == 3'd2), arith & (f3 == 3'd3), arith & (f3 == 3'd1),
                                arith & (f3 == 3'd5) & ~f7[5], arith & (f3 == 3'd5) & f7[5], sel};
  assign be = (f3[1:0] == 2'b00) ? 4'b0001 : (f3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
  assign mem_op = (ill | ~(c_ld | c_st)) ? 10'b0
                : {c_ld & ~f3[2], f3[1:0] == 2'b00, f3[1:0] == 2'b01, f3[1:0] == 2'b10, c_ld, c_st, be};
  assign mul_op = {is_m, is_m ? f3 : 3'b0};
  assign bt = (f3 == 3'd0) ? is_zero : (f3 == 3'd1) ? ~is_zero : (f3 == 3'd4) ? is_lt
            : (f3 == 3'd5) ? ~is_lt : (f3 == 3'd6) ? is_ltu : (f3 == 3'd7) ? ~is_ltu : 1'b0;
  assign taken = ~ill & (c_jal | c_jalr | (c_br & bt));
  assign target = ((c_jalr ? qa : in_pc) + imm) & ~32'd1;
  assign ent = {in_pc, we ? rd : 5'b0, use1 ? rs1 : 5'b0, use2 ? rs2 : 5'b0,
                ~ill & (c_lui | c_auipc | c_jal | c_jalr), ~ill & (c_lui | c_auipc | c_jal | c_jalr | c_ld | c_st | c_opi),
                (c_auipc | c_jal | c_jalr) ? in_pc : 32'b0, (c_jal | c_jalr) ? 32'd4 : imm,
                alu_op, mem_op, we, mul_op, ill};
  // Interlock: branch/jalr operands resolve here, so any in-flight producer stalls them; loads stall every consumer
  always_comb begin
    buf_hz = 1'b0;
    for (int i = 0; i < BUF_DEPTH; i++)
      if (vld[i] && buf_q[i][WE_BIT] && (((c_br | c_jalr) && buf_q[i][RD_LSB+:5] == rs1) || (c_br && buf_q[i][RD_LSB+:5] == rs2)))
        buf_hz = 1'b1;
    stall = in_valid & ~ill & (buf_hz
          | ((ex_rd != 5'b0) & (((c_br | c_jalr) & (rs1 == ex_rd)) | (c_br & (rs2 == ex_rd))))
          | ((ex_rd != 5'b0) & ex_is_load & ((use1 & (rs1 == ex_rd)) | (use2 & (rs2 == ex_rd)))));
  end
  // Wrong-path shadow state register
  always_ff @(posedge clk)
    if (rst) state <= NORMAL;
    else state <= state_n;
  // One shadow cycle follows every accepted taken instruction
  always_comb state_n = (flush || state == SHADOW) ? NORMAL : (push && taken) ? SHADOW : NORMAL;
  // Shadow cycles swallow the wrong-path fetch; otherwise accept when space and no hazard
  always_comb in_ready = (state == SHADOW) | ((count < CW'(BUF_DEPTH)) & ~stall);
  assign push = in_valid & in_ready & (state == NORMAL) & ~flush;
  assign pop = out_valid & out_ready;
  // FIFO bookkeeping and registered redirect
  always_ff @(posedge clk)
    if (rst) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      vld <= '0;
      redirect <= 1'b0;
      redirect_addr <= 32'b0;
    end else if (flush) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      vld <= '0;
      redirect <= 1'b0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= (wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push) vld[wr_ptr] <= 1'b1;
      if (pop) vld[rd_ptr] <= 1'b0;
      redirect <= push & taken;
      if (push && taken) redirect_addr <= target;
    end
  // Entry storage; validity lives in vld so the payload needs no reset
  always_ff @(posedge clk)
    if (push) buf_q[wr_ptr] <= ent;
  assign out_valid = vld[rd_ptr];
  assign {out_pc, out_rd, out_rs1, out_rs2, out_alu_src_1, out_alu_src_2, out_alu_imm_1, out_alu_imm_2,
          out_alu_op, out_mem_op, out_reg_we, out_mul_op, out_illegal} = out_valid ? buf_q[rd_ptr] : '0;
endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: directed checks of id_pipe decode, FIFO, hazards, redirect and flush
module tb_id_pipe;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, is_lt = 0, is_ltu = 0, is_zero = 0;
  logic ex_is_load = 0, flush = 0, out_valid, out_ready = 0, out_alu_src_1, out_alu_src_2;
  logic out_reg_we, out_illegal, redirect;
  logic [31:0] in_pc = 0, in_inst = 0, qa = 0, out_pc, out_alu_imm_1, out_alu_imm_2, redirect_addr;
  logic [4:0] ex_rd = 0, out_rd, out_rs1, out_rs2;
  logic [7:0] out_alu_op;
  logic [9:0] out_mem_op;
  logic [3:0] out_mul_op;
  int passed = 0, total = 0;
  id_pipe dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .qa(qa), .is_lt(is_lt), .is_ltu(is_ltu), .is_zero(is_zero), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_alu_src_1(out_alu_src_1), .out_alu_src_2(out_alu_src_2), .out_alu_imm_1(out_alu_imm_1),
    .out_alu_imm_2(out_alu_imm_2), .out_alu_op(out_alu_op), .out_mem_op(out_mem_op),
    .out_reg_we(out_reg_we), .out_mul_op(out_mul_op), .out_illegal(out_illegal),
    .redirect(redirect), .redirect_addr(redirect_addr));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1;
    in_pc = pc;
    in_inst = inst;
  endtask
  task automatic one(input logic [31:0] pc, input logic [31:0] inst);
    tick();
    offer(pc, inst);
    tick();
    in_valid = 0;
    #2;
  endtask
  task automatic drain();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask
  initial begin
    tick();
    tick();
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_redirect", redirect, 0);
    check("rst_redirect_addr", redirect_addr, 0);
    check("rst_out_pc", out_pc, 0);
    rst = 0;
    #1;
    check("rst_in_ready", in_ready, 1);
    one(32'h100, 32'h00500093);
    check("addi_valid", out_valid, 1);
    check("addi_pc", out_pc, 32'h100);
    check("addi_imm2", out_alu_imm_2, 5);
    check("addi_we", out_reg_we, 1);
    check("addi_rd", out_rd, 1);
    check("addi_alu_op", out_alu_op, 8'h03);
    check("addi_src2", out_alu_src_2, 1);
    drain();
    tick();
    offer(32'h10, 32'h00100113);
    tick();
    offer(32'h14, 32'h00200193);
    tick();
    offer(32'h18, 32'h00300213);
    out_ready = 1;
    #2;
    check("full_in_ready", in_ready, 0);
    check("fifo_a", out_pc, 32'h10);
    tick();
    #2;
    check("after_pop_in_ready", in_ready, 1);
    check("fifo_b", out_pc, 32'h14);
    tick();
    in_valid = 0;
    #2;
    check("fifo_c", out_pc, 32'h18);
    check("fifo_c_rd", out_rd, 4);
    tick();
    out_ready = 0;
    #2;
    check("fifo_empty", out_valid, 0);
    tick();
    offer(32'h200, 32'h04000063);
    is_zero = 1;
    out_ready = 1;
    #2;
    check("beq_in_ready", in_ready, 1);
    tick();
    offer(32'h204, 32'h00500293);
    #2;
    check("beq_redirect", redirect, 1);
    check("beq_target", redirect_addr, 32'h240);
    check("shadow_in_ready", in_ready, 1);
    check("beq_delivered", out_pc, 32'h200);
    check("beq_we", out_reg_we, 0);
    tick();
    in_valid = 0;
    is_zero = 0;
    #2;
    check("redirect_pulse", redirect, 0);
    check("shadow_dropped", out_valid, 0);
    out_ready = 0;
    tick();
    offer(32'h300, 32'h004100E7);
    qa = 32'h1003;
    #2;
    check("jalr_in_ready", in_ready, 1);
    tick();
    in_valid = 0;
    #2;
    check("jalr_redirect", redirect, 1);
    check("jalr_target", redirect_addr, 32'h1006);
    check("jalr_imm1", out_alu_imm_1, 32'h300);
    check("jalr_imm2", out_alu_imm_2, 4);
    check("jalr_src1", out_alu_src_1, 1);
    drain();
    tick();
    ex_rd = 5;
    ex_is_load = 1;
    offer(32'h400, 32'h00728333);
    #2;
    check("load_use_stall", in_ready, 0);
    tick();
    #2;
    check("load_use_stall2", in_ready, 0);
    check("load_use_nopush", out_valid, 0);
    ex_rd = 8;
    #1;
    check("load_use_release", in_ready, 1);
    tick();
    in_valid = 0;
    drain();
    ex_rd = 5;
    ex_is_load = 0;
    offer(32'h404, 32'h00728333);
    #2;
    check("nonload_accept", in_ready, 1);
    tick();
    in_valid = 0;
    #2;
    check("add_rd", out_rd, 6);
    check("add_rs1", out_rs1, 5);
    check("add_rs2", out_rs2, 7);
    check("add_src2", out_alu_src_2, 0);
    drain();
    offer(32'h408, 32'h04028063);
    #2;
    check("br_ex_stall", in_ready, 0);
    ex_rd = 0;
    #1;
    check("br_ex_release", in_ready, 1);
    tick();
    in_valid = 0;
    drain();
    offer(32'h40, 32'h00500293);
    tick();
    offer(32'h44, 32'h04028063);
    #2;
    check("br_buf_stall", in_ready, 0);
    out_ready = 1;
    tick();
    #2;
    check("br_buf_release", in_ready, 1);
    tick();
    in_valid = 0;
    tick();
    out_ready = 0;
    offer(32'h10, 32'h00100113);
    tick();
    offer(32'h14, 32'h00200193);
    tick();
    offer(32'h500, 32'h008000EF);
    flush = 1;
    tick();
    in_valid = 0;
    flush = 0;
    #2;
    check("flush_full_valid", out_valid, 0);
    check("flush_full_redirect", redirect, 0);
    offer(32'h10, 32'h00100113);
    tick();
    offer(32'h500, 32'h008000EF);
    flush = 1;
    #2;
    check("flush_jal_in_ready", in_ready, 1);
    tick();
    in_valid = 0;
    flush = 0;
    #2;
    check("flush_jal_valid", out_valid, 0);
    check("flush_jal_redirect", redirect, 0);
    check("flush_normal", in_ready, 1);
    one(32'h600, 32'h023100B3);
`ifdef RV32M_EN
    check("mul_op", out_mul_op, 4'b1000);
    check("mul_illegal", out_illegal, 0);
    check("mul_we", out_reg_we, 1);
    check("mul_alu_op", out_alu_op, 0);
`else
    check("mul_op", out_mul_op, 0);
    check("mul_illegal", out_illegal, 1);
    check("mul_we", out_reg_we, 0);
`endif
    drain();
    one(32'h604, 32'hFFFFFFFF);
    check("bad_illegal", out_illegal, 1);
    check("bad_we", out_reg_we, 0);
    check("bad_mem", out_mem_op, 0);
    check("bad_no_redirect", redirect, 0);
    drain();
    one(32'h608, 32'h00013083);
    check("ld_f3_illegal", out_illegal, 1);
    drain();
    one(32'h60C, 32'h00012083);
    check("lw_mem", out_mem_op, 10'h26F);
    check("lw_legal", out_illegal, 0);
    drain();
    one(32'h610, 32'h00312223);
    check("sw_mem", out_mem_op, 10'h05F);
    check("sw_imm2", out_alu_imm_2, 4);
    check("sw_we", out_reg_we, 0);
    drain();
    offer(32'h700, 32'h008000EF);
    tick();
    in_valid = 0;
    #2;
    check("jal_redirect", redirect_addr, 32'h708);
    rst = 1;
    tick();
    #2;
    check("midrst_valid", out_valid, 0);
    check("midrst_redirect", redirect, 0);
    check("midrst_addr", redirect_addr, 0);
    rst = 0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
